// File: rtl/blit_pkg.sv
// blit_pkg: mode encodings, FSM states and width helper shared by the blitter files
package blit_pkg;
  typedef enum logic [1:0] {
    MODE_OPAQUE = 2'b00,
    MODE_TRANSP = 2'b01,
    MODE_CLEAR  = 2'b10,
    MODE_RSVD   = 2'b11
  } mode_e;
  typedef enum logic [1:0] {ST_IDLE, ST_SCAN, ST_FLUSH, ST_DONE} state_e;
  function automatic int bits(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/blit_if.sv
// blit_if: control, ROM read and pixel-write signals between controller, ROM, blitter and adapter
interface blit_if import blit_pkg::*; #(
  parameter int SCREEN_W    = 160,
  parameter int SCREEN_H    = 120,
  parameter int IMG_W       = 160,
  parameter int IMG_H       = 120,
  parameter int NUM_IMAGES  = 4,
  parameter int COLOUR_BITS = 3
) ();
  localparam int X_BITS    = bits(SCREEN_W);
  localparam int Y_BITS    = bits(SCREEN_H);
  localparam int I_BITS    = bits(NUM_IMAGES);
  localparam int ADDR_BITS = bits(NUM_IMAGES * IMG_W * IMG_H);
  logic                   start;
  logic [1:0]             mode;
  logic [I_BITS-1:0]      img_sel;
  logic [X_BITS-1:0]      x0;
  logic [Y_BITS-1:0]      y0;
  logic [COLOUR_BITS-1:0] fill_colour;
  logic [ADDR_BITS-1:0]   rom_addr;
  logic [COLOUR_BITS-1:0] rom_q;
  logic                   plot;
  logic [X_BITS-1:0]      x;
  logic [Y_BITS-1:0]      y;
  logic [COLOUR_BITS-1:0] colour;
  logic                   busy;
  logic                   done;
  modport master (
    output start, mode, img_sel, x0, y0, fill_colour, rom_q,
    input  rom_addr, plot, x, y, colour, busy, done
  );
  modport slave (
    input  start, mode, img_sel, x0, y0, fill_colour, rom_q,
    output rom_addr, plot, x, y, colour, busy, done
  );
endinterface

// File: rtl/blit_pipe.sv
// blit_pipe: DEPTH-stage delay of {valid, clip, x, y} so coordinates line up with rom_q
module blit_pipe #(
  parameter int DEPTH = 1,
  parameter int XB    = 8,
  parameter int YB    = 7
) (
  input  logic          CLOCK_50,
  input  logic          reset_n,
  input  logic          valid_in,
  input  logic          clip_in,
  input  logic [XB-1:0] x_in,
  input  logic [YB-1:0] y_in,
  output logic          valid_out,
  output logic          clip_out,
  output logic [XB-1:0] x_out,
  output logic [YB-1:0] y_out
);
  localparam int W = XB + YB + 2;
  logic [W-1:0] sr [DEPTH];
  always_ff @(posedge CLOCK_50 or negedge reset_n)
    if (!reset_n)
      for (int i = 0; i < DEPTH; i++) sr[i] <= '0;
    else begin
      sr[0] <= {valid_in, clip_in, x_in, y_in};
      for (int i = 1; i < DEPTH; i++) sr[i] <= sr[i-1];
    end
  assign {valid_out, clip_out, x_out, y_out} = sr[DEPTH-1];
endmodule

// File: rtl/image_blitter.sv
// image_blitter: start/busy/done raster copy of a ROM image (or a solid fill) into the VGA pixel port
module image_blitter import blit_pkg::*; #(
  parameter int SCREEN_W    = 160,
  parameter int SCREEN_H    = 120,
  parameter int IMG_W       = 160,
  parameter int IMG_H       = 120,
  parameter int NUM_IMAGES  = 4,
  parameter int COLOUR_BITS = 3,
  parameter int ROM_LATENCY = 1,
  parameter int KEY_COLOUR  = 0
) (
  input logic   CLOCK_50,
  input logic   reset_n,
  blit_if.slave bus
);
  localparam int X_BITS    = bits(SCREEN_W);
  localparam int Y_BITS    = bits(SCREEN_H);
  localparam int I_BITS    = bits(NUM_IMAGES);
  localparam int ADDR_BITS = bits(NUM_IMAGES * IMG_W * IMG_H);
  localparam int MW        = IMG_W > SCREEN_W ? IMG_W : SCREEN_W;
  localparam int MH        = IMG_H > SCREEN_H ? IMG_H : SCREEN_H;
  localparam int CW        = bits(MW);
  localparam int RW        = bits(MH);
  localparam int DW        = (X_BITS > CW ? X_BITS : CW) + 1;
  localparam int DH        = (Y_BITS > RW ? Y_BITS : RW) + 1;
  localparam logic [ADDR_BITS-1:0] IMG_SZ = ADDR_BITS'(IMG_W * IMG_H);
  localparam logic [ADDR_BITS-1:0] ROW_SZ = ADDR_BITS'(IMG_W);
  state_e                 state, state_n;
  logic [1:0]             mode_r;
  logic [I_BITS-1:0]      img_r;
  logic [X_BITS-1:0]      x0_r;
  logic [Y_BITS-1:0]      y0_r;
  logic [COLOUR_BITS-1:0] fill_r;
  logic [CW-1:0]          col, w_m1;
  logic [RW-1:0]          row, h_m1;
  logic [1:0]             fcnt;
  logic                   clear, col_end, last, scan, clip;
  logic [DW-1:0]          dx;
  logic [DH-1:0]          dy;
  logic                   p_valid, p_clip;
  logic [X_BITS-1:0]      p_x;
  logic [Y_BITS-1:0]      p_y;
  always_comb begin
    clear   = mode_r == MODE_CLEAR;
    scan    = state == ST_SCAN;
    w_m1    = clear ? CW'(SCREEN_W - 1) : CW'(IMG_W - 1);
    h_m1    = clear ? RW'(SCREEN_H - 1) : RW'(IMG_H - 1);
    col_end = col == w_m1;
    last    = col_end && row == h_m1;
    dx      = (clear ? DW'(0) : DW'(x0_r)) + DW'(col);
    dy      = (clear ? DH'(0) : DH'(y0_r)) + DH'(row);
    clip    = dx >= DW'(SCREEN_W) || dy >= DH'(SCREEN_H);
  end
  always_comb begin
    state_n = state;
    case (state)
      ST_IDLE:  state_n = bus.start ? ST_SCAN : ST_IDLE;
      ST_SCAN:  state_n = last ? ST_FLUSH : ST_SCAN;
      ST_FLUSH: state_n = fcnt == 2'(ROM_LATENCY - 1) ? ST_DONE : ST_FLUSH;
      ST_DONE:  state_n = ST_IDLE;
      default:  state_n = ST_IDLE;
    endcase
  end
  always_ff @(posedge CLOCK_50 or negedge reset_n)
    if (!reset_n) state <= ST_IDLE;
    else state <= state_n;
  always_ff @(posedge CLOCK_50 or negedge reset_n)
    if (!reset_n) begin
      mode_r <= '0;
      img_r  <= '0;
      x0_r   <= '0;
      y0_r   <= '0;
      fill_r <= '0;
      col    <= '0;
      row    <= '0;
      fcnt   <= '0;
    end else if (state == ST_IDLE && bus.start) begin
      mode_r <= bus.mode;
      img_r  <= bus.img_sel;
      x0_r   <= bus.x0;
      y0_r   <= bus.y0;
      fill_r <= bus.fill_colour;
      col    <= '0;
      row    <= '0;
      fcnt   <= '0;
    end else if (scan) begin
      col <= col_end ? '0 : col + 1'b1;
      row <= col_end ? row + 1'b1 : row;
    end else if (state == ST_FLUSH) fcnt <= fcnt + 1'b1;
  blit_pipe #(.DEPTH(ROM_LATENCY), .XB(X_BITS), .YB(Y_BITS)) u_pipe (
    .CLOCK_50 (CLOCK_50),
    .reset_n  (reset_n),
    .valid_in (scan),
    .clip_in  (clip),
    .x_in     (dx[X_BITS-1:0]),
    .y_in     (dy[Y_BITS-1:0]),
    .valid_out(p_valid),
    .clip_out (p_clip),
    .x_out    (p_x),
    .y_out    (p_y)
  );
  // outputs are pipe registers qualified by rom_q, which is itself registered inside the ROM
  assign bus.rom_addr = scan && !clear ? ADDR_BITS'(img_r) * IMG_SZ + ADDR_BITS'(row) * ROW_SZ + ADDR_BITS'(col) : '0;
  assign bus.busy     = scan || state == ST_FLUSH;
  assign bus.done     = state == ST_DONE;
  assign bus.plot     = p_valid && !p_clip && !(mode_r == MODE_TRANSP && bus.rom_q == COLOUR_BITS'(KEY_COLOUR));
  assign bus.x        = p_x;
  assign bus.y        = p_y;
  assign bus.colour   = !p_valid ? '0 : clear ? fill_r : bus.rom_q;
endmodule

// File: tb/tb_image_blitter.sv
// tb_image_blitter: table-driven blits on an 8x6 screen with 4x2 images, plus start/reset corner cases
module tb_image_blitter;
  logic clk, reset_n;
  int checks = 0, errors = 0;
  int r_n, r_dk, r_bad, r_abad, r_fx, r_fy, r_fc, r_lx, r_ly, r_lc;
  typedef struct {
    logic [1:0] mode;
    logic       img;
    logic [2:0] x0, y0, fill;
    int n, fx, fy, fc, lx, ly, lc, dk;
  } vec_t;
  vec_t vecs[7];
  blit_if #(.SCREEN_W(8), .SCREEN_H(6), .IMG_W(4), .IMG_H(2), .NUM_IMAGES(2), .COLOUR_BITS(3)) bus ();
  image_blitter #(.SCREEN_W(8), .SCREEN_H(6), .IMG_W(4), .IMG_H(2), .NUM_IMAGES(2),
                  .COLOUR_BITS(3), .ROM_LATENCY(1), .KEY_COLOUR(0)) dut (
    .CLOCK_50(clk),
    .reset_n (reset_n),
    .bus     (bus)
  );
  initial clk = 0;
  always #5 clk = ~clk;
  always @(posedge clk) bus.rom_q <= bus.rom_addr[2:0];
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  task automatic run_blit(input vec_t v);
    int np, ea, ec;
    np = v.mode == 2'd2 ? 48 : 8;
    r_n = 0; r_dk = -1; r_bad = 0; r_abad = 0;
    r_fx = -1; r_fy = -1; r_fc = -1; r_lx = -1; r_ly = -1; r_lc = -1;
    @(negedge clk);
    bus.mode = v.mode; bus.img_sel = v.img; bus.x0 = v.x0; bus.y0 = v.y0;
    bus.fill_colour = v.fill; bus.start = 1;
    for (int k = 1; k <= 200 && r_dk < 0; k++) begin
      @(negedge clk);
      bus.start = 0;
      if (k <= np) begin
        ea = v.mode == 2'd2 ? 0 : int'(v.img) * 8 + k - 1;
        if (int'(bus.rom_addr) != ea) r_abad++;
      end
      if (bus.plot) begin
        ec = v.mode == 2'd2 ? int'(v.fill) : ((int'(bus.y) - int'(v.y0)) * 4 + int'(bus.x) - int'(v.x0)) % 8;
        if (int'(bus.colour) != ec || bus.x > 3'd7 || bus.y > 3'd5) r_bad++;
        if (r_n == 0) begin r_fx = bus.x; r_fy = bus.y; r_fc = bus.colour; end
        r_lx = bus.x; r_ly = bus.y; r_lc = bus.colour;
        r_n++;
      end
      if (bus.done) r_dk = k;
    end
  endtask
  task automatic check_vec(input string t, input vec_t v);
    chk({t, "_plots"}, r_n, v.n);
    chk({t, "_first_x"}, r_fx, v.fx);
    chk({t, "_first_y"}, r_fy, v.fy);
    chk({t, "_first_c"}, r_fc, v.fc);
    chk({t, "_last_x"}, r_lx, v.lx);
    chk({t, "_last_y"}, r_ly, v.ly);
    chk({t, "_last_c"}, r_lc, v.lc);
    chk({t, "_done_cycle"}, r_dk, v.dk);
    chk({t, "_pixel_model"}, r_bad, 0);
    chk({t, "_rom_addr"}, r_abad, 0);
  endtask
  initial begin
    int dones, plots, fx;
    vecs[0] = '{2'd0, 1'b1, 3'd2, 3'd1, 3'd0, 8, 2, 1, 0, 5, 2, 7, 10};
    vecs[1] = '{2'd0, 1'b0, 3'd6, 3'd5, 3'd0, 2, 6, 5, 0, 7, 5, 1, 10};
    vecs[2] = '{2'd1, 1'b0, 3'd0, 3'd0, 3'd0, 7, 1, 0, 1, 3, 1, 7, 10};
    vecs[3] = '{2'd2, 1'b1, 3'd3, 3'd2, 3'd5, 48, 0, 0, 5, 7, 5, 5, 50};
    vecs[4] = '{2'd3, 1'b0, 3'd4, 3'd4, 3'd0, 8, 4, 4, 0, 7, 5, 7, 10};
    vecs[5] = '{2'd1, 1'b1, 3'd1, 3'd0, 3'd0, 7, 2, 0, 1, 4, 1, 7, 10};
    vecs[6] = '{2'd0, 1'b1, 3'd7, 3'd0, 3'd0, 2, 7, 0, 0, 7, 1, 4, 10};
    reset_n = 0;
    bus.start = 0; bus.mode = 0; bus.img_sel = 0; bus.x0 = 0; bus.y0 = 0; bus.fill_colour = 0;
    repeat (2) @(negedge clk);
    chk("rst_plot", int'(bus.plot), 0);
    chk("rst_x", int'(bus.x), 0);
    chk("rst_y", int'(bus.y), 0);
    chk("rst_colour", int'(bus.colour), 0);
    chk("rst_rom_addr", int'(bus.rom_addr), 0);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_done", int'(bus.done), 0);
    reset_n = 1;
    repeat (2) @(negedge clk);
    chk("idle_busy", int'(bus.busy), 0);
    for (int i = 0; i < 7; i++) begin
      run_blit(vecs[i]);
      check_vec($sformatf("vec%0d", i), vecs[i]);
    end
    // start held high with new inputs throughout a blit and its done cycle
    @(negedge clk);
    bus.mode = 2'd0; bus.img_sel = 0; bus.x0 = 0; bus.y0 = 0; bus.start = 1;
    dones = 0; plots = 0; fx = -1; r_dk = -1;
    for (int k = 1; k <= 200 && r_dk < 0; k++) begin
      @(negedge clk);
      bus.mode = 2'd2; bus.x0 = 3'd5; bus.fill_colour = 3'd6;
      if (bus.plot) begin
        if (plots == 0) fx = bus.x;
        plots++;
      end
      if (bus.done) begin dones++; r_dk = k; end
    end
    chk("hold_done_cycle", r_dk, 10);
    chk("hold_done_count", dones, 1);
    chk("hold_plots", plots, 8);
    chk("hold_first_x", fx, 0);
    @(negedge clk);
    chk("start_in_done_ignored", int'(bus.busy), 0);
    @(negedge clk);
    chk("start_after_done_accepted", int'(bus.busy), 1);
    bus.start = 0;
    dones = 0; plots = 0;
    for (int k = 0; k < 200 && dones == 0; k++) begin
      if (bus.plot) plots++;
      if (bus.done) dones++;
      if (bus.plot && bus.colour != 3'd6) plots += 1000;
      @(negedge clk);
    end
    chk("b2b_done_count", dones, 1);
    chk("b2b_clear_plots", plots, 48);
    // reset while pixel 3 is on the output
    @(negedge clk);
    bus.mode = 2'd0; bus.img_sel = 1; bus.x0 = 3'd2; bus.y0 = 3'd1; bus.start = 1;
    @(negedge clk);
    bus.start = 0;
    repeat (4) @(negedge clk);
    chk("pre_reset_plot", int'(bus.plot), 1);
    chk("pre_reset_x", int'(bus.x), 5);
    reset_n = 0;
    #1;
    chk("abort_plot", int'(bus.plot), 0);
    chk("abort_busy", int'(bus.busy), 0);
    chk("abort_done", int'(bus.done), 0);
    repeat (2) @(negedge clk);
    reset_n = 1;
    dones = 0; plots = 0;
    repeat (15) begin
      @(negedge clk);
      if (bus.busy || bus.plot) plots++;
      if (bus.done) dones++;
    end
    chk("no_resume_activity", plots, 0);
    chk("no_resume_done", dones, 0);
    run_blit(vecs[0]);
    check_vec("after_reset", vecs[0]);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
